lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller between the single-cycle core's memory stage and the word-wide data memory. It accepts one architectural load or store per handshake, covering LB/LH/LW/LBU/LHU and SB/SH/SW. Each request becomes word-aligned memory accesses: one read for loads, one write for SW, and a read-modify-write for SB/SH. It extracts, sign-extends and byte-merges data, and flags misaligned or illegal requests without touching memory.

## Interface
- `MEM_SIZE`, default 4096: data memory depth in words. Requests with `req_addr >= MEM_SIZE*4` are errors.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with `resp_valid`: misaligned, illegal funct3 or out of range.
- `resp_rdata`  out  32  load result, valid with `resp_valid`. Zero for stores and errors.
- `mem_a`  out  32  word-aligned byte address: `{addr[31:2],2'b00}`.
- `mem_rde`  out  1  memory read enable. Data returns on `mem_rd` the cycle after.
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  32  write data. `wd[8k+7:8k]` goes to byte `a+k`.
- `mem_rd`  in  32  read data. Byte `a+k` arrives on `rd[31-8k -: 8]` (reversed lanes).

## Operation
- States: IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR.
- IDLE → next state on `req_valid`. Request fields are registered on acceptance; later input changes are ignored.
- Next-state from IDLE:
  - LW/LH/LB/LHU/LBU → LD_RD.
  - SW → ST_WR.
  - SB/SH → RMW_RD.
  - Misaligned or illegal → ERR.
- Misaligned: H access with `addr[0]=1`; W access with `addr[1:0]!=0`.
- Illegal funct3: loads 011/110/111; stores 011–111.
- LD_RD: `mem_rde=1` → LD_RSP.
- LD_RSP: lane-swap `mem_rd` into little-endian word L (`L[8k+7:8k]` = byte k).
  - Select the byte or half at offset `addr[1:0]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - `resp_valid=1` → IDLE.
- ST_WR: `mem_we=1`, `mem_wd=req_wdata`, `resp_valid=1` → IDLE.
- RMW_RD: `mem_rde=1` → RMW_WR.
- RMW_WR: form L from `mem_rd`, then replace lane(s) at the offset with `wdata[7:0]` or `wdata[15:0]`.
  - Drive `mem_we=1`, `mem_wd=L`, `resp_valid=1` → IDLE.
- ERR: `resp_valid=1`, `resp_err=1`, no memory enable → IDLE.
- `mem_rde` and `mem_we` are never high together.
- `mem_a` holds the registered aligned address in all non-IDLE states and is 0 in IDLE.

## Timing
- Reset values, effective the cycle after `reset` is sampled high:
  - state IDLE.
  - `req_ready=1`.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`.
  - `mem_rde=0`, `mem_we=0`, `mem_a=0`, `mem_wd=0`.
- Cycle 0 is the accept edge. Latency to `resp_valid`:
  - load: cycle 2.
  - SW: cycle 1.
  - SB/SH: cycle 2.
  - error: cycle 1.
- All outputs decode from registered state and registers only; no combinational path from `req_*` to `mem_*`.
- Throughput: a new request is accepted the cycle after `resp_valid`. No back-to-back overlap.
- `reset` in any state aborts the access. If asserted during RMW_RD, no write is issued and memory is unchanged.

## Structure
- `lsu_pkg`:
  - state enum.
  - funct3 localparams (`F3_B=3'b000`, `F3_H=001`, `F3_W=010`, `F3_BU=100`, `F3_HU=101`).
  - `lane_swap` function.
- Sub-module `lsu_align` (combinational) holds extract/extend and merge logic. Inputs: funct3, offset, L, wdata. Outputs: load result and merged word.
- `lsu_ctrl` holds the FSM and request registers.

## Test plan
- SW 0x10 ← 0x11223344 → cycle 1: `mem_we=1`, `mem_a=0x10`, `mem_wd=0x11223344`, `resp_valid=1`.
- LW 0x10, memory returns `mem_rd=0x44332211` → cycle 2: `resp_rdata=0x11223344`, `resp_err=0`.
- SB 0x12 ← 0x000000A5 over memory word 0x11223344 → `mem_rde` cycle 1, `mem_wd=0x11A53344` cycle 2.
- Loads after that SB:
  - LB 0x12 → `0xFFFFFFA5`.
  - LBU 0x12 → `0x000000A5`.
  - LH 0x12 → `0x000011A5`.
- Error requests:
  - LH 0x11 → cycle 1: `resp_valid=1`, `resp_err=1`, `resp_rdata=0`, `mem_rde`/`mem_we` never high.
  - Same response for SW funct3=011.
- Reset asserted in RMW_RD of SH 0x14 → next cycle IDLE, `req_ready=1`, `mem_we` never asserted.
- Reset value check: all outputs equal their listed reset values the cycle after `reset` is sampled high.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: FSM states,
// RV32I load/store funct3 encodings and the memory lane-order swap.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_RSP,
    ST_WR,
    RMW_RD,
    RMW_WR,
    ERR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory returns byte a+k in the top lanes; reversing bytes yields a little-endian word.
  function automatic logic [31:0] lane_swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core-side request/response handshake and the data-memory port.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a;
  logic        mem_rde;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_a, mem_rde, mem_we, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_a, mem_rde, mem_we, mem_wd
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte/half extraction with sign/zero extension for loads and
// lane merge of store data into a little-endian memory word for SB/SH.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic        [7:0]  byte_sel;
  logic        [15:0] half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    byte_s   = byte_sel;
    half_s   = half_sel;
    case (funct3)
      F3_B:    load_data = 32'(byte_s);
      F3_H:    load_data = 32'(half_s);
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    if (funct3[1:0] == 2'b00)
      merged[{offset, 3'b000} +: 8] = wdata[7:0];
    else if (funct3[1:0] == 2'b01)
      merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller FSM: turns one RV32I load/store per handshake into
// word-aligned memory reads, writes or read-modify-writes.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4096
) (
  input logic   clk,
  input logic   reset,
  lsu_if.slave  bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_SIZE) << 2;

  state_t      state;
  logic        ready_q;
  logic        rvalid_q;
  logic        rerr_q;
  logic        rde_q;
  logic        mwe_q;
  logic [31:0] mem_a_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Request classification only steers the next state; it never reaches mem_* directly.
  always_comb begin
    if (bus.req_we)
      illegal = bus.req_funct3 > F3_W;
    else
      illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                (bus.req_funct3 == 3'b111);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = {1'b0, bus.req_addr} >= ADDR_LIMIT;
    req_err      = illegal || misaligned || out_of_range;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rde_q    <= 1'b0;
      mwe_q    <= 1'b0;
      mem_a_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rde_q    <= 1'b0;
      mwe_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            mem_a_q <= {bus.req_addr[31:2], 2'b00};
            if (req_err) begin
              state    <= ERR;
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
            end else if (!bus.req_we) begin
              state <= LD_RD;
              rde_q <= 1'b1;
            end else if (bus.req_funct3 == F3_W) begin
              state    <= ST_WR;
              mwe_q    <= 1'b1;
              rvalid_q <= 1'b1;
            end else begin
              state <= RMW_RD;
              rde_q <= 1'b1;
            end
          end
        end
        LD_RD: begin
          state    <= LD_RSP;
          rvalid_q <= 1'b1;
        end
        RMW_RD: begin
          state    <= RMW_WR;
          mwe_q    <= 1'b1;
          rvalid_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          mem_a_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      funct3_q <= bus.req_funct3;
      offset_q <= bus.req_addr[1:0];
      wdata_q  <= bus.req_wdata;
    end
  end

  lsu_align u_align (
    .funct3    (funct3_q),
    .offset    (offset_q),
    .word      (lane_swap(bus.mem_rd)),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  // Response/write data qualify on state so they read zero outside their cycle.
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = rerr_q;
  assign bus.mem_rde    = rde_q;
  assign bus.mem_we     = mwe_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.resp_rdata = (state == LD_RSP) ? load_data : '0;
  assign bus.mem_wd     = (state == RMW_WR) ? merged :
                          (state == ST_WR)  ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: memory read data is driven by hand with the
// reversed lane order the data memory uses.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  lsu_if bus ();

  lsu_ctrl #(.MEM_SIZE(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_rd = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready got=%0h exp=1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%0h exp=0", bus.resp_valid); else passed++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL rst_resp_err got=%0h exp=0", bus.resp_err); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL rst_rdata got=%08h exp=00000000", bus.resp_rdata); else passed++;
    total++; if (bus.mem_rde !== 1'b0) $display("FAIL rst_rde got=%0h exp=0", bus.mem_rde); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_we got=%0h exp=0", bus.mem_we); else passed++;
    total++; if (bus.mem_a !== 32'h0) $display("FAIL rst_mem_a got=%08h exp=00000000", bus.mem_a); else passed++;
    total++; if (bus.mem_wd !== 32'h0) $display("FAIL rst_mem_wd got=%08h exp=00000000", bus.mem_wd); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_sw();
    issue(1'b1, 3'b010, 32'h10, 32'h1122_3344);
    total++; if (bus.mem_we !== 1'b1) $display("FAIL sw_we got=%0h exp=1", bus.mem_we); else passed++;
    total++; if (bus.mem_a !== 32'h10) $display("FAIL sw_mem_a got=%08h exp=00000010", bus.mem_a); else passed++;
    total++; if (bus.mem_wd !== 32'h1122_3344) $display("FAIL sw_mem_wd got=%08h exp=11223344", bus.mem_wd); else passed++;
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL sw_resp_valid got=%0h exp=1", bus.resp_valid); else passed++;
    total++; if (bus.mem_rde !== 1'b0) $display("FAIL sw_rde got=%0h exp=0", bus.mem_rde); else passed++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL sw_err got=%0h exp=0", bus.resp_err); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL sw_ready_after got=%0h exp=1", bus.req_ready); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL sw_we_after got=%0h exp=0", bus.mem_we); else passed++;
    total++; if (bus.mem_a !== 32'h0) $display("FAIL sw_mem_a_idle got=%08h exp=00000000", bus.mem_a); else passed++;
  endtask

  task automatic test_lw();
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    total++; if (bus.mem_rde !== 1'b1) $display("FAIL lw_rde got=%0h exp=1", bus.mem_rde); else passed++;
    total++; if (bus.mem_a !== 32'h10) $display("FAIL lw_mem_a got=%08h exp=00000010", bus.mem_a); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL lw_early_valid got=%0h exp=0", bus.resp_valid); else passed++;
    @(posedge clk);
    #1;
    bus.mem_rd = 32'h4433_2211;
    #1;
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL lw_resp_valid got=%0h exp=1", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'h1122_3344) $display("FAIL lw_rdata got=%08h exp=11223344", bus.resp_rdata); else passed++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL lw_err got=%0h exp=0", bus.resp_err); else passed++;
    total++; if (bus.mem_rde !== 1'b0) $display("FAIL lw_rde_drop got=%0h exp=0", bus.mem_rde); else passed++;
    @(posedge clk);
    #1;
    bus.mem_rd = 32'h0;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL lw_ready_after got=%0h exp=1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL lw_valid_pulse got=%0h exp=0", bus.resp_valid); else passed++;
  endtask

  task automatic test_rmw(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd,
                          input logic [31:0] exp_wd);
    issue(1'b1, f3, addr, wdata);
    total++; if (bus.mem_rde !== 1'b1) $display("FAIL rmw_rde addr=%08h got=%0h exp=1", addr, bus.mem_rde); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL rmw_we_early addr=%08h got=%0h exp=0", addr, bus.mem_we); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL rmw_valid_early addr=%08h got=%0h exp=0", addr, bus.resp_valid); else passed++;
    @(posedge clk);
    #1;
    bus.mem_rd = rd;
    #1;
    total++; if (bus.mem_we !== 1'b1) $display("FAIL rmw_we addr=%08h got=%0h exp=1", addr, bus.mem_we); else passed++;
    total++; if (bus.mem_rde !== 1'b0) $display("FAIL rmw_rde_late addr=%08h got=%0h exp=0", addr, bus.mem_rde); else passed++;
    total++; if (bus.mem_wd !== exp_wd) $display("FAIL rmw_wd addr=%08h got=%08h exp=%08h", addr, bus.mem_wd, exp_wd); else passed++;
    total++; if (bus.mem_a !== {addr[31:2], 2'b00}) $display("FAIL rmw_mem_a got=%08h exp=%08h", bus.mem_a, {addr[31:2], 2'b00}); else passed++;
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL rmw_valid addr=%08h got=%0h exp=1", addr, bus.resp_valid); else passed++;
    @(posedge clk);
    #1;
    bus.mem_rd = 32'h0;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL rmw_ready_after addr=%08h got=%0h exp=1", addr, bus.req_ready); else passed++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3   [8] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b000, 3'b000, 3'b010};
    logic [31:0] addr [8] = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13, 32'h11, 32'h3FFC};
    logic [31:0] rd   [8] = '{32'h4433_A511, 32'h4433_A511, 32'h4433_A511, 32'h0180_A511,
                              32'h0180_A511, 32'h4433_A511, 32'h4433_A511, 32'h7856_3412};
    logic [31:0] exp  [8] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'h0000_11A5, 32'hFFFF_8001,
                              32'h0000_8001, 32'h0000_0011, 32'h0000_0033, 32'h1234_5678};
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, f3[i], addr[i], 32'h0);
      total++; if (bus.mem_a !== {addr[i][31:2], 2'b00}) $display("FAIL ld%0d_mem_a got=%08h exp=%08h", i, bus.mem_a, {addr[i][31:2], 2'b00}); else passed++;
      @(posedge clk);
      #1;
      bus.mem_rd = rd[i];
      #1;
      total++; if (bus.resp_valid !== 1'b1) $display("FAIL ld%0d_valid got=%0h exp=1", i, bus.resp_valid); else passed++;
      total++; if (bus.resp_rdata !== exp[i]) $display("FAIL ld%0d_rdata got=%08h exp=%08h", i, bus.resp_rdata, exp[i]); else passed++;
      @(posedge clk);
      #1;
      bus.mem_rd = 32'h0;
    end
  endtask

  task automatic test_errors();
    logic        we   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3   [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b010, 3'b000};
    logic [31:0] addr [6] = '{32'h11, 32'h20, 32'h12, 32'h0, 32'h4000, 32'h4001};
    for (int i = 0; i < 6; i++) begin
      issue(we[i], f3[i], addr[i], 32'hCAFE_F00D);
      bus.mem_rd = 32'h1234_5678;
      #1;
      total++; if (bus.resp_valid !== 1'b1) $display("FAIL err%0d_valid got=%0h exp=1", i, bus.resp_valid); else passed++;
      total++; if (bus.resp_err !== 1'b1) $display("FAIL err%0d_err got=%0h exp=1", i, bus.resp_err); else passed++;
      total++; if (bus.resp_rdata !== 32'h0) $display("FAIL err%0d_rdata got=%08h exp=00000000", i, bus.resp_rdata); else passed++;
      total++; if (bus.mem_rde !== 1'b0 || bus.mem_we !== 1'b0) $display("FAIL err%0d_mem_en got=%0h%0h exp=00", i, bus.mem_rde, bus.mem_we); else passed++;
      @(posedge clk);
      #1;
      bus.mem_rd = 32'h0;
      total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL err%0d_after got=%0h%0h exp=10", i, bus.req_ready, bus.resp_valid); else passed++;
      total++; if (bus.mem_rde !== 1'b0 || bus.mem_we !== 1'b0) $display("FAIL err%0d_mem_en_after got=%0h%0h exp=00", i, bus.mem_rde, bus.mem_we); else passed++;
    end
  endtask

  task automatic test_rmw_reset();
    issue(1'b1, 3'b001, 32'h14, 32'h0000_BEEF);
    total++; if (bus.mem_rde !== 1'b1) $display("FAIL rstrmw_rde got=%0h exp=1", bus.mem_rde); else passed++;
    reset = 1'b1;
    bus.mem_rd = 32'h4433_2211;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL rstrmw_ready got=%0h exp=1", bus.req_ready); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL rstrmw_we got=%0h exp=0", bus.mem_we); else passed++;
    total++; if (bus.mem_a !== 32'h0) $display("FAIL rstrmw_mem_a got=%08h exp=00000000", bus.mem_a); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL rstrmw_valid got=%0h exp=0", bus.resp_valid); else passed++;
    @(posedge clk);
    #1;
    bus.mem_rd = 32'h0;
    total++; if (bus.mem_we !== 1'b0 || bus.mem_wd !== 32'h0) $display("FAIL rstrmw_we_late got=%0h/%08h exp=0/00000000", bus.mem_we, bus.mem_wd); else passed++;
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'b010, 32'h20, 32'hA1B2_C3D4);
    total++; if (bus.mem_wd !== 32'hA1B2_C3D4) $display("FAIL b2b_wd got=%08h exp=a1b2c3d4", bus.mem_wd); else passed++;
    @(posedge clk);
    #1;
    issue(1'b0, 3'b010, 32'h24, 32'h0);
    total++; if (bus.mem_rde !== 1'b1 || bus.mem_a !== 32'h24) $display("FAIL b2b_second got=%0h/%08h exp=1/00000024", bus.mem_rde, bus.mem_a); else passed++;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready got=%0h exp=1", bus.req_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lw();
    test_rmw(3'b000, 32'h12, 32'h1234_56A5, 32'h4433_2211, 32'h11A5_3344);
    test_loads();
    test_errors();
    test_rmw_reset();
    test_rmw(3'b001, 32'h16, 32'h0000_BEEF, 32'h4433_2211, 32'hBEEF_3344);
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
